// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: mux select codes,
// shadow-slot layout and the "slot writes register" predicate.
package fwd_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 3;
    localparam int CNT_W_DEF      = 16;

    // Slot rd field is sized for the widest supported register address;
    // narrower addresses are zero-extended before comparison.
    localparam int RD_MAX_W = 8;

    localparam logic [1:0] FWD_SEL_REG = 2'd0;
    localparam logic [1:0] FWD_SEL_MEM = 2'd1;
    localparam logic [1:0] FWD_SEL_WB  = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic slot_writes(input slot_t s,
                                         input logic [RD_MAX_W-1:0] r,
                                         input logic zero_reg);
        return s.valid && s.reg_write && (s.rd == r) && !(zero_reg && (r == '0));
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and EX-stage control bundle between the pipeline and the
// forwarding/hazard controller.
interface fwd_hazard_ctrl_if
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
);
    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  stall;
    logic [1:0]            fwd_sel_a;
    logic [1:0]            fwd_sel_b;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read,
        input  stall, fwd_sel_a, fwd_sel_b, stall_count
    );

    modport slave (
        input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read,
        output stall, fwd_sel_a, fwd_sel_b, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl_src_match.sv
// Per-operand source matcher: compares one ID source against the EX and MEM
// shadow slots and returns the forwarding select plus a load-use hit.
module fwd_src_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ZERO_REG   = 1
) (
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] src,
    input  slot_t                 ex_slot,
    input  slot_t                 mem_slot,
    output logic                  load_hit,
    output logic [1:0]            sel
);
    logic [RD_MAX_W-1:0] src_ext;
    logic                ex_hit;
    logic                mem_hit;
    logic                unused_mem_load;

    assign src_ext = RD_MAX_W'(src);
    assign ex_hit  = src_used && slot_writes(ex_slot,  src_ext, ZERO_REG != 0);
    assign mem_hit = src_used && slot_writes(mem_slot, src_ext, ZERO_REG != 0);

    // A load already in MEM has its data by the time the consumer reaches EX.
    assign unused_mem_load = mem_slot.mem_read;

    // EX producer is the newest and lands in MEM when the consumer is in EX;
    // a MEM producer lands in WB.
    always_comb begin
        sel = FWD_SEL_REG;
        if (ex_hit) begin
            sel = FWD_SEL_MEM;
        end else if (mem_hit) begin
            sel = FWD_SEL_WB;
        end
    end

    assign load_hit = ex_hit && ex_slot.mem_read;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows the EX/MEM/WB destination
// registers and drives registered operand-mux selects plus a stall request.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam int N_SRC = 2;

    slot_t                 ex_reg;
    slot_t                 mem_reg;
    slot_t                 wb_reg;
    slot_t                 id_slot;
    logic [1:0]            sel_reg   [N_SRC];
    logic [1:0]            sel_next  [N_SRC];
    logic                  load_hit  [N_SRC];
    logic [REG_ADDR_W-1:0] src       [N_SRC];
    logic                  src_used  [N_SRC];
    logic                  stall_next;
    logic [CNT_W-1:0]      stall_count_reg;
    logic                  unused_wb;

    assign src[0]      = bus.id_rs1;
    assign src[1]      = bus.id_rs2;
    assign src_used[0] = bus.id_valid && bus.id_use_rs1;
    assign src_used[1] = bus.id_valid && bus.id_use_rs2;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            fwd_src_match #(
                .REG_ADDR_W (REG_ADDR_W),
                .ZERO_REG   (ZERO_REG)
            ) u_match (
                .src_used (src_used[gi]),
                .src      (src[gi]),
                .ex_slot  (ex_reg),
                .mem_slot (mem_reg),
                .load_hit (load_hit[gi]),
                .sel      (sel_next[gi])
            );
        end
    endgenerate

    // Flush kills the ID instruction, so it can never be the one stalling.
    assign stall_next = bus.id_valid && (load_hit[0] || load_hit[1]) && !bus.flush;

    always_comb begin
        id_slot           = SLOT_EMPTY;
        id_slot.valid     = bus.id_valid;
        id_slot.rd        = RD_MAX_W'(bus.id_rd);
        id_slot.reg_write = bus.id_reg_write;
        id_slot.mem_read  = bus.id_mem_read;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg          <= SLOT_EMPTY;
            mem_reg         <= SLOT_EMPTY;
            wb_reg          <= SLOT_EMPTY;
            stall_count_reg <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                sel_reg[i] <= FWD_SEL_REG;
            end
        end else if (!bus.hold) begin
            // Older instructions always advance; only the ID entry is gated.
            mem_reg <= ex_reg;
            wb_reg  <= mem_reg;
            if (bus.flush || stall_next) begin
                ex_reg <= SLOT_EMPTY;
                for (int i = 0; i < N_SRC; i++) begin
                    sel_reg[i] <= FWD_SEL_REG;
                end
            end else begin
                ex_reg <= id_slot;
                for (int i = 0; i < N_SRC; i++) begin
                    sel_reg[i] <= sel_next[i];
                end
            end
            if (stall_next && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
        end
    end

    // WB slot only mirrors retirement for debug visibility; nothing forwards from it.
    assign unused_wb = ^wb_reg;

    assign bus.stall       = stall_next;
    assign bus.fwd_sel_a   = sel_reg[0];
    assign bus.fwd_sel_b   = sel_reg[1];
    assign bus.stall_count = stall_count_reg;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl: a 16-bit-counter instance and a
// 2-bit-counter instance share stimulus so counter saturation is reachable.
module tb_fwd_hazard_ctrl;
    import fwd_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(3), .CNT_W(16)) bus ();
    fwd_hazard_ctrl_if #(.REG_ADDR_W(3), .CNT_W(2))  bus_sat ();

    assign bus_sat.hold         = bus.hold;
    assign bus_sat.flush        = bus.flush;
    assign bus_sat.id_valid     = bus.id_valid;
    assign bus_sat.id_rs1       = bus.id_rs1;
    assign bus_sat.id_rs2       = bus.id_rs2;
    assign bus_sat.id_use_rs1   = bus.id_use_rs1;
    assign bus_sat.id_use_rs2   = bus.id_use_rs2;
    assign bus_sat.id_rd        = bus.id_rd;
    assign bus_sat.id_reg_write = bus.id_reg_write;
    assign bus_sat.id_mem_read  = bus.id_mem_read;

    fwd_hazard_ctrl #(.REG_ADDR_W(3), .ZERO_REG(1), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fwd_hazard_ctrl #(.REG_ADDR_W(3), .ZERO_REG(1), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, want);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input bit u1,
                         input bit u2, input int rd, input bit rw, input bit mr);
        bus.id_valid     = v;
        bus.id_rs1       = 3'(rs1);
        bus.id_rs2       = 3'(rs2);
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        bus.id_rd        = 3'(rd);
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        drive(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic lw(input int rd, input int rs1);
        drive(1'b1, rs1, rs1, 1'b1, 1'b0, rd, 1'b1, 1'b1);
    endtask

    // One ID cycle: stall is checked mid-cycle, registered outputs after the edge.
    task automatic step(input string tag, input bit fl, input bit hd, input bit rs,
                        input bit exp_stall, input int exp_a, input int exp_b, input int exp_cnt);
        exp_t e;
        int   sat;
        bus.flush = fl;
        bus.hold  = hd;
        rst       = rs;
        e.tag   = tag;
        e.stall = exp_stall;
        e.sel_a = 2'(exp_a);
        e.sel_b = 2'(exp_b);
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check({e.tag, ".stall"}, 32'(bus.stall), 32'(e.stall));
        @(posedge clk);
        #1;
        sat = (e.cnt > 3) ? 3 : e.cnt;
        check({e.tag, ".sel_a"}, 32'(bus.fwd_sel_a), 32'(e.sel_a));
        check({e.tag, ".sel_b"}, 32'(bus.fwd_sel_b), 32'(e.sel_b));
        check({e.tag, ".cnt"},   32'(bus.stall_count), 32'(e.cnt));
        check({e.tag, ".cnt_sat"}, 32'(bus_sat.stall_count), 32'(sat));
        $display("step %-10s stall=%0b sel_a=%0d sel_b=%0d cnt=%0d cnt_sat=%0d",
                 e.tag, bus.stall, bus.fwd_sel_a, bus.fwd_sel_b, bus.stall_count,
                 bus_sat.stall_count);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall",   32'(bus.stall),       32'd0);
        check("reset.sel_a",   32'(bus.fwd_sel_a),   32'd0);
        check("reset.sel_b",   32'(bus.fwd_sel_b),   32'd0);
        check("reset.cnt",     32'(bus.stall_count), 32'd0);
        check("reset.cnt_sat", 32'(bus_sat.stall_count), 32'd0);
        $display("step %-10s stall=%0b sel_a=%0d sel_b=%0d cnt=%0d", "reset",
                 bus.stall, bus.fwd_sel_a, bus.fwd_sel_b, bus.stall_count);

        // ALU forwarding at distance 1 and 2, WB not forwarded, newest wins.
        alu(3, 1, 2);           step("alu_r3",    0, 0, 0, 0, 0, 0, 0);
        alu(4, 3, 5);           step("dist1",     0, 0, 0, 0, 1, 0, 0);
        alu(7, 6, 6);           step("unrel",     0, 0, 0, 0, 0, 0, 0);
        alu(2, 4, 3);           step("dist2",     0, 0, 0, 0, 2, 0, 0);
        alu(3, 1, 1);           step("r3_a",      0, 0, 0, 0, 0, 0, 0);
        alu(3, 3, 2);           step("self_rd",   0, 0, 0, 0, 1, 2, 0);
        alu(6, 3, 3);           step("newest",    0, 0, 0, 0, 1, 1, 0);

        // Load-use with rs1 == rs2.
        lw(2, 6);               step("lw_r2",     0, 0, 0, 0, 1, 0, 0);
        alu(6, 2, 2);           step("lu_stall",  0, 0, 0, 1, 0, 0, 1);
        alu(6, 2, 2);           step("lu_issue",  0, 0, 0, 0, 2, 2, 1);

        // r0 is never forwarded, even from a load.
        alu(0, 1, 1);           step("wr_r0",     0, 0, 0, 0, 0, 0, 1);
        alu(5, 0, 0);           step("rd_r0_ex",  0, 0, 0, 0, 0, 0, 1);
        lw(0, 0);               step("rd_r0_mem", 0, 0, 0, 0, 0, 0, 1);
        alu(4, 0, 0);           step("r0_load",   0, 0, 0, 0, 0, 0, 1);

        // Invalid ID instruction matching an EX producer.
        drive(1'b0, 4, 4, 1'b1, 1'b1, 5, 1'b1, 1'b0);
                                step("id_inv",    0, 0, 0, 0, 0, 0, 1);

        // Flush during load-use: stall suppressed, older slots still advance.
        lw(1, 2);               step("lw_r1",     0, 0, 0, 0, 0, 0, 1);
        alu(2, 1, 1);           step("flush",     1, 0, 0, 0, 0, 0, 1);
        alu(3, 1, 0);           step("post_fl",   0, 0, 0, 0, 2, 0, 1);

        // Hold for three cycles across a pending load-use stall.
        lw(4, 3);               step("lw_r4",     0, 0, 0, 0, 1, 0, 1);
        alu(6, 4, 3);           step("hold1",     0, 1, 0, 1, 1, 0, 1);
        alu(6, 4, 3);           step("hold2",     0, 1, 0, 1, 1, 0, 1);
        alu(6, 4, 3);           step("hold3",     0, 1, 0, 1, 1, 0, 1);
        alu(6, 4, 3);           step("post_hold", 0, 0, 0, 1, 0, 0, 2);
        alu(6, 4, 3);           step("hold_iss",  0, 0, 0, 0, 2, 0, 2);

        // Reset while a stall is pending.
        lw(7, 1);               step("lw_r7",     0, 0, 0, 0, 0, 0, 2);
        alu(1, 7, 7);           step("rst_stall", 0, 0, 1, 1, 0, 0, 0);
        alu(1, 7, 7);           step("after_rst", 0, 0, 0, 0, 0, 0, 0);

        // Repeated load-use pairs drive the narrow counter into saturation.
        for (int i = 0; i < 5; i++) begin
            lw(1, 2);           step($sformatf("sat_lw%0d", i),  0, 0, 0, 0, 0, 0, i);
            alu(3, 1, 1);       step($sformatf("sat_st%0d", i),  0, 0, 0, 1, 0, 0, i + 1);
            alu(3, 1, 1);       step($sformatf("sat_is%0d", i),  0, 0, 0, 0, 2, 2, i + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
